// File: rtl/vga_pkg.sv
// Shared timing constants for the VGA raster generator: the default
// 640x480@60 mode, an alternate 800x600@72 mode, and small helpers used
// to derive totals and validate counter widths at elaboration.
package vga_pkg;

   localparam int DEF_COORD_W  = 11;
   localparam int DEF_COLOUR_W = 8;

   // 640x480@60, 25 MHz pixel clock, 800x525 totals, both syncs active-low
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FRONT  = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BACK   = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FRONT  = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BACK   = 33;
   localparam bit VGA640_H_POL    = 1'b0;
   localparam bit VGA640_V_POL    = 1'b0;

   // 800x600@72, 50 MHz pixel clock, 1040x666 totals, both syncs active-high
   localparam int VGA800_H_ACTIVE = 800;
   localparam int VGA800_H_FRONT  = 56;
   localparam int VGA800_H_SYNC   = 120;
   localparam int VGA800_H_BACK   = 64;
   localparam int VGA800_V_ACTIVE = 600;
   localparam int VGA800_V_FRONT  = 37;
   localparam int VGA800_V_SYNC   = 6;
   localparam int VGA800_V_BACK   = 23;
   localparam bit VGA800_H_POL    = 1'b1;
   localparam bit VGA800_V_POL    = 1'b1;

   // Positions per line (or lines per frame) for one axis
   function automatic int axis_total(input int act, input int front, input int sync, input int back);
      return act + front + sync + back;
   endfunction

   // True when a counter of width w can reach every position 0..total-1
   function automatic bit coord_fits(input int total, input int w);
      return total <= (1 << w);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source and DAC-side signals of the raster generator. The generator
// side (master) receives colour and drives coordinates, strobes and pins.
interface vga_timing_gen_if
   import vga_pkg::*;
#(
   parameter int COLOUR_W = DEF_COLOUR_W,
   parameter int COORD_W  = DEF_COORD_W
);
   logic [COLOUR_W-1:0] colour_R;
   logic [COLOUR_W-1:0] colour_G;
   logic [COLOUR_W-1:0] colour_B;
   logic [COORD_W-1:0]  x_pos;
   logic [COORD_W-1:0]  y_pos;
   logic                active;
   logic                line_start;
   logic                frame_start;
   logic                vga_hsync;
   logic                vga_vsync;
   logic                vga_blank_n;
   logic [COLOUR_W-1:0] R;
   logic [COLOUR_W-1:0] G;
   logic [COLOUR_W-1:0] B;

   modport master (
      input  colour_R, colour_G, colour_B,
      output x_pos, y_pos, active, line_start, frame_start,
      output vga_hsync, vga_vsync, vga_blank_n, R, G, B
   );

   modport slave (
      output colour_R, colour_G, colour_B,
      input  x_pos, y_pos, active, line_start, frame_start,
      input  vga_hsync, vga_vsync, vga_blank_n, R, G, B
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a 0..TOTAL-1 position counter laid out as
// active, front porch, sync, back porch, with region flags and a wrap strobe.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = VGA640_H_ACTIVE,
   parameter int FRONT  = VGA640_H_FRONT,
   parameter int SYNC   = VGA640_H_SYNC,
   parameter int BACK   = VGA640_H_BACK,
   parameter int CW     = DEF_COORD_W
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          advance,
   output logic [CW-1:0] count,
   output logic          in_active,
   output logic          in_sync,
   output logic          wrap
);

   localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
   localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FRONT);
   localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FRONT + SYNC);

   generate
      if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_timing
         $error("vga_axis_counter: every active/porch/sync length must be at least 1");
      end
      if (!coord_fits(TOTAL, CW)) begin : g_bad_width
         $error("vga_axis_counter: counter width too small for axis total");
      end
   endgenerate

   logic at_last;

   assign at_last   = (count == LAST);
   assign wrap      = advance && at_last;
   assign in_active = (count < ACT_END);
   assign in_sync   = (count >= SYNC_START) && (count < SYNC_END);

   // Position counter: reset wins, otherwise step or wrap on each advance
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (advance) begin
         if (at_last) begin
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator. Two axis counters produce the current
// coordinate and sync regions; a single pixel-enabled register stage puts
// colour, blank and syncs on the DAC pins together, one pixel after the
// coordinate is exported.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = VGA640_H_ACTIVE,
   parameter int H_FRONT    = VGA640_H_FRONT,
   parameter int H_SYNC     = VGA640_H_SYNC,
   parameter int H_BACK     = VGA640_H_BACK,
   parameter int V_ACTIVE   = VGA640_V_ACTIVE,
   parameter int V_FRONT    = VGA640_V_FRONT,
   parameter int V_SYNC     = VGA640_V_SYNC,
   parameter int V_BACK     = VGA640_V_BACK,
   parameter bit H_SYNC_POL = VGA640_H_POL,
   parameter bit V_SYNC_POL = VGA640_V_POL,
   parameter int COLOUR_W   = DEF_COLOUR_W,
   parameter int COORD_W    = DEF_COORD_W
) (
   input  logic clock,
   input  logic reset,
   input  logic pix_ce,
   vga_timing_gen_if.master bus
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

   generate
      if (!coord_fits(H_TOTAL, COORD_W) || !coord_fits(V_TOTAL, COORD_W)) begin : g_coord_check
         $error("vga_timing_gen: COORD_W cannot hold max(H_TOTAL, V_TOTAL)");
      end
   endgenerate

   logic [COORD_W-1:0] h_count;
   logic [COORD_W-1:0] v_count;
   logic               h_active;
   logic               h_sync;
   logic               h_wrap;
   logic               v_active;
   logic               v_sync;
   logic               pix_active;

   // Horizontal axis steps once per enabled pixel
   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CW(COORD_W)
   ) u_h_axis (
      .clock     (clock),
      .reset     (reset),
      .advance   (pix_ce),
      .count     (h_count),
      .in_active (h_active),
      .in_sync   (h_sync),
      .wrap      (h_wrap)
   );

   // Vertical axis steps only on the line wrap, so vsync is line-granular
   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CW(COORD_W)
   ) u_v_axis (
      .clock     (clock),
      .reset     (reset),
      .advance   (h_wrap),
      .count     (v_count),
      .in_active (v_active),
      .in_sync   (v_sync),
      .wrap      ()
   );

   assign pix_active      = h_active && v_active;
   assign bus.x_pos       = h_count;
   assign bus.y_pos       = v_count;
   assign bus.active      = pix_active;
   assign bus.line_start  = pix_ce && (h_count == '0);
   assign bus.frame_start = pix_ce && (h_count == '0) && (v_count == '0);

   // DAC boundary register: sync, blank and colour advance together per pixel
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.vga_hsync   <= ~H_SYNC_POL;
         bus.vga_vsync   <= ~V_SYNC_POL;
         bus.vga_blank_n <= 1'b0;
         bus.R           <= '0;
         bus.G           <= '0;
         bus.B           <= '0;
      end else if (pix_ce) begin
         bus.vga_hsync   <= h_sync ? H_SYNC_POL : ~H_SYNC_POL;
         bus.vga_vsync   <= v_sync ? V_SYNC_POL : ~V_SYNC_POL;
         bus.vga_blank_n <= pix_active;
         bus.R           <= pix_active ? bus.colour_R : '0;
         bus.G           <= pix_active ? bus.colour_G : '0;
         bus.B           <= pix_active ? bus.colour_B : '0;
      end else begin
         bus.vga_hsync   <= bus.vga_hsync;
         bus.vga_vsync   <= bus.vga_vsync;
         bus.vga_blank_n <= bus.vga_blank_n;
         bus.R           <= bus.R;
         bus.G           <= bus.G;
         bus.B           <= bus.B;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-raster
// instance share clock, reset and pixel enable. A frame-linear reference model
// (pixel index within the frame, split into x/y by division) predicts every
// output each cycle; a vector table and a few measured periods cover corners.
module tb_vga_timing_gen;

   typedef struct {
      int ha, hf, hsw, hb;
      int va, vf, vsw, vb;
      bit hpol, vpol;
   } tim_t;

   typedef struct {
      int         p;
      bit         hs, vs, bn;
      logic [7:0] r, g, b;
   } mdl_t;

   typedef struct packed {
      logic [10:0] x, y;
      logic        act, ls, fs, hs, vs, bn;
      logic [7:0]  r, g, b;
   } obs_t;

   typedef struct {
      bit ce, rst;
      int x, y;
      bit ls, fs;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b1;
   always #5 clk = ~clk;

   vga_timing_gen_if #(.COLOUR_W(8), .COORD_W(11)) bus_a ();
   vga_timing_gen_if #(.COLOUR_W(8), .COORD_W(11)) bus_b ();

   vga_timing_gen dut_a (
      .clock (clk), .reset (rst), .pix_ce (ce), .bus (bus_a.master)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
   ) dut_b (
      .clock (clk), .reset (rst), .pix_ce (ce), .bus (bus_b.master)
   );

   obs_t obs_a, obs_b;
   assign obs_a = {bus_a.x_pos, bus_a.y_pos, bus_a.active, bus_a.line_start, bus_a.frame_start,
                   bus_a.vga_hsync, bus_a.vga_vsync, bus_a.vga_blank_n, bus_a.R, bus_a.G, bus_a.B};
   assign obs_b = {bus_b.x_pos, bus_b.y_pos, bus_b.active, bus_b.line_start, bus_b.frame_start,
                   bus_b.vga_hsync, bus_b.vga_vsync, bus_b.vga_blank_n, bus_b.R, bus_b.G, bus_b.B};

   tim_t ta = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
   tim_t tb = '{4, 2, 2, 2, 3, 1, 1, 1, 1'b1, 1'b0};
   mdl_t ma = '{0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
   mdl_t mb = '{0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
   bit   armed = 1'b0;

   int vectors    = 0;
   int miscompares = 0;

   function automatic int h_tot(tim_t t);
      return t.ha + t.hf + t.hsw + t.hb;
   endfunction

   function automatic int v_tot(tim_t t);
      return t.va + t.vf + t.vsw + t.vb;
   endfunction

   // Outputs expected while the model sits at frame pixel m.p
   function automatic obs_t expect_obs(tim_t t, mdl_t m, bit c);
      obs_t o;
      int h, v;
      h = m.p % h_tot(t);
      v = m.p / h_tot(t);
      o.x   = 11'(h);
      o.y   = 11'(v);
      o.act = (h < t.ha) && (v < t.va);
      o.ls  = c && (h == 0);
      o.fs  = c && (m.p == 0);
      o.hs  = m.hs;
      o.vs  = m.vs;
      o.bn  = m.bn;
      o.r   = m.r;
      o.g   = m.g;
      o.b   = m.b;
      return o;
   endfunction

   // One clock of the reference: reset, advance one pixel, or hold
   function automatic mdl_t model_next(tim_t t, mdl_t m, bit c, bit r,
                                       logic [7:0] cr, logic [7:0] cg, logic [7:0] cb);
      mdl_t n;
      int h, v;
      bit act, in_h, in_v;
      n = m;
      h = m.p % h_tot(t);
      v = m.p / h_tot(t);
      act  = (h < t.ha) && (v < t.va);
      in_h = (h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hsw);
      in_v = (v >= t.va + t.vf) && (v < t.va + t.vf + t.vsw);
      if (r) begin
         n = '{0, ~t.hpol, ~t.vpol, 1'b0, 8'h00, 8'h00, 8'h00};
      end else if (c) begin
         n.hs = in_h ? t.hpol : ~t.hpol;
         n.vs = in_v ? t.vpol : ~t.vpol;
         n.bn = act;
         n.r  = act ? cr : 8'h00;
         n.g  = act ? cg : 8'h00;
         n.b  = act ? cb : 8'h00;
         n.p  = (m.p + 1) % (h_tot(t) * v_tot(t));
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then compare both DUTs
   task automatic drive_and_check(input bit c, input bit r, input bit rnd);
      @(negedge clk);
      ce  = c;
      rst = r;
      if (rnd) begin
         bus_a.colour_R = 8'($urandom); bus_a.colour_G = 8'($urandom); bus_a.colour_B = 8'($urandom);
         bus_b.colour_R = 8'($urandom); bus_b.colour_G = 8'($urandom); bus_b.colour_B = 8'($urandom);
      end else begin
         bus_a.colour_R = 8'(ma.p % h_tot(ta)); bus_a.colour_G = 8'(ma.p / h_tot(ta)); bus_a.colour_B = 8'hA5;
         bus_b.colour_R = 8'(mb.p % h_tot(tb)); bus_b.colour_G = 8'(mb.p / h_tot(tb)); bus_b.colour_B = 8'hA5;
      end
      #1;
      if (armed) begin
         check("dut_a_outputs", 64'(obs_a), 64'(expect_obs(ta, ma, c)));
         check("dut_b_outputs", 64'(obs_b), 64'(expect_obs(tb, mb, c)));
      end
   endtask

   task automatic advance();
      @(posedge clk);
      ma = model_next(ta, ma, ce, rst, bus_a.colour_R, bus_a.colour_G, bus_a.colour_B);
      mb = model_next(tb, mb, ce, rst, bus_b.colour_R, bus_b.colour_G, bus_b.colour_B);
      armed = 1'b1;
   endtask

   vec_t tbl [15];

   initial begin
      int a_ls [$];
      int b_fs [$];
      int a_low_first, a_low_cnt, b_hs_hi, b_vs_lo, strobe_on_hold, guard;

      tbl[0]  = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 2, 0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 2, 0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 3, 0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 4, 0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 5, 0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 6, 0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 7, 0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 8, 0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 9, 0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 0, 1, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1, 1, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1, 1, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1};

      // Reset held for three enabled cycles
      for (int i = 0; i < 3; i++) begin
         drive_and_check(1'b1, 1'b1, 1'b0);
         advance();
      end

      // Full-rate pixel clock with coordinate-derived colour
      a_low_first = -1; a_low_cnt = 0; b_hs_hi = 0; b_vs_lo = 0;
      for (int cyc = 0; cyc < 1700; cyc++) begin
         drive_and_check(1'b1, 1'b0, 1'b0);
         if (cyc == 0) check("frame_start_after_reset", 64'(bus_a.frame_start), 64'(1));
         if (bus_a.line_start) a_ls.push_back(cyc);
         if (cyc < 800 && bus_a.vga_hsync == 1'b0) begin
            a_low_cnt++;
            if (a_low_first < 0) a_low_first = cyc;
         end
         if (bus_b.frame_start) b_fs.push_back(cyc);
         if (cyc >= 1 && cyc <= 60) begin
            if (bus_b.vga_hsync == 1'b1) b_hs_hi++;
            if (bus_b.vga_vsync == 1'b0) b_vs_lo++;
         end
         advance();
      end
      check("line_period", 64'(a_ls.size() >= 2 ? a_ls[1] - a_ls[0] : -1), 64'(800));
      check("hsync_low_width", 64'(a_low_cnt), 64'(96));
      // sync region starts at h=656; the pin follows one pixel later
      check("hsync_low_start", 64'(a_low_first), 64'(657));
      check("small_frame_period", 64'(b_fs.size() >= 2 ? b_fs[1] - b_fs[0] : -1), 64'(60));
      check("small_hsync_high_per_frame", 64'(b_hs_hi), 64'(12));
      check("small_vsync_low_per_frame", 64'(b_vs_lo), 64'(10));

      // Advance to x=300 on line 2, then a single-cycle reset mid-frame
      guard = 0;
      while ((ma.p % h_tot(ta)) != 300 && guard < 1000) begin
         drive_and_check(1'b1, 1'b0, 1'b0);
         advance();
         guard++;
      end
      check("reach_x300", 64'(ma.p % h_tot(ta)), 64'(300));
      drive_and_check(1'b1, 1'b1, 1'b0);
      advance();

      // Vector table on the small raster; first row is also the post-reset pixel
      for (int i = 0; i < 15; i++) begin
         drive_and_check(tbl[i].ce, tbl[i].rst, 1'b0);
         check("tbl_x", 64'(bus_b.x_pos), 64'(tbl[i].x));
         check("tbl_y", 64'(bus_b.y_pos), 64'(tbl[i].y));
         check("tbl_line_start", 64'(bus_b.line_start), 64'(tbl[i].ls));
         check("tbl_frame_start", 64'(bus_b.frame_start), 64'(tbl[i].fs));
         if (i == 0) begin
            check("abort_xy", 64'({bus_a.x_pos, bus_a.y_pos}), 64'(0));
            check("abort_frame_start", 64'(bus_a.frame_start), 64'(1));
            check("abort_pins", 64'({bus_a.vga_hsync, bus_a.vga_vsync, bus_a.vga_blank_n, bus_a.R}),
                  64'(11'b110_0000_0000));
         end
         advance();
      end

      // Half-rate pixel enable: periods double, strobes never on hold cycles
      b_fs.delete();
      strobe_on_hold = 0;
      for (int cyc = 0; cyc < 1600; cyc++) begin
         drive_and_check((cyc % 2) == 0, 1'b0, 1'b0);
         if (bus_b.frame_start) b_fs.push_back(cyc);
         if ((cyc % 2) == 1 && (bus_a.line_start || bus_a.frame_start ||
                                bus_b.line_start || bus_b.frame_start)) strobe_on_hold++;
         advance();
      end
      check("half_rate_frame_period", 64'(b_fs.size() >= 2 ? b_fs[1] - b_fs[0] : -1), 64'(120));
      check("strobes_on_hold_cycles", 64'(strobe_on_hold), 64'(0));

      // Random enable, random colour, occasional reset
      for (int cyc = 0; cyc < 4000; cyc++) begin
         drive_and_check($urandom_range(0, 2) != 0, $urandom_range(0, 799) == 0, 1'b1);
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
